// File: rtl/fetch_queue.sv
// Dual-wide in-order instruction queue between fetch and issue: up to two
// pushes and two pops per cycle, unique non-zero IDs, empty slots read as 0.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INSTRUCTION_ID_WIDTH
`define INSTRUCTION_ID_WIDTH 6
`endif

module fetch_queue #(
  parameter int DEPTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [1:0]                       fetch_vld,
  input  logic [`INST_WIDTH-1:0]           fetch_instruction0,
  input  logic [`INST_WIDTH-1:0]           fetch_instruction1,
  input  logic [`ADDR_WIDTH-1:0]           fetch_pc0,
  input  logic [`ADDR_WIDTH-1:0]           fetch_pc1,
  output logic                             fetch_ready,
  input  logic                             stall_in,
  output logic [`INST_WIDTH-1:0]           instruction0_out,
  output logic [`INST_WIDTH-1:0]           instruction1_out,
  output logic [`ADDR_WIDTH-1:0]           pc0_out,
  output logic [`ADDR_WIDTH-1:0]           pc1_out,
  output logic [`INSTRUCTION_ID_WIDTH-1:0] id0_out,
  output logic [`INSTRUCTION_ID_WIDTH-1:0] id1_out,
  output logic [DEPTH_LOG2:0]              count
);

  typedef logic [`INSTRUCTION_ID_WIDTH-1:0] id_t;
  typedef logic [DEPTH_LOG2-1:0]            ptr_t;
  typedef logic [DEPTH_LOG2:0]              cnt_t;

  typedef struct packed {
    logic [`INST_WIDTH-1:0] inst;
    logic [`ADDR_WIDTH-1:0] pc;
    id_t                    id;
  } entry_t;

  localparam ptr_t PTR_ONE   = ptr_t'(1);
  localparam cnt_t CNT_ONE   = cnt_t'(1);
  localparam cnt_t CNT_TWO   = cnt_t'(2);
  localparam cnt_t READY_MAX = cnt_t'(DEPTH - 2);
  localparam id_t  ID_ONE    = id_t'(1);

  entry_t mem_q [DEPTH];
  ptr_t   head_q, head_d;
  ptr_t   tail_q, tail_d;
  cnt_t   count_q, count_d;
  id_t    next_id_q, next_id_d;
  cnt_t   push_cnt, pop_cnt;
  logic   wr_a, wr_b;
  entry_t entry_a, entry_b;
  entry_t slot0, slot1;

  // ID 0 is the NOP encoding, so the sequence wraps from all-ones to 1.
  function automatic id_t id_inc(input id_t id);
    return (id == '1) ? ID_ONE : id + ID_ONE;
  endfunction

  assign fetch_ready = (count_q <= READY_MAX);

  // NOTE: every variable gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    push_cnt = '0;
    pop_cnt  = '0;
    if (!flush) begin
      if (fetch_ready) push_cnt = {{(DEPTH_LOG2-1){1'b0}}, &fetch_vld, ^fetch_vld};
      if (!stall_in)   pop_cnt  = (count_q >= CNT_TWO) ? CNT_TWO : count_q;
    end

    wr_a = (push_cnt != '0);
    wr_b = (push_cnt == CNT_TWO);

    // A lone bit1 is compacted into the first free entry.
    entry_a.inst = fetch_vld[0] ? fetch_instruction0 : fetch_instruction1;
    entry_a.pc   = fetch_vld[0] ? fetch_pc0 : fetch_pc1;
    entry_a.id   = next_id_q;
    entry_b.inst = fetch_instruction1;
    entry_b.pc   = fetch_pc1;
    entry_b.id   = id_inc(next_id_q);

    next_id_d = next_id_q;
    if (wr_b)      next_id_d = id_inc(id_inc(next_id_q));
    else if (wr_a) next_id_d = id_inc(next_id_q);

    head_d  = head_q + ptr_t'(pop_cnt);
    tail_d  = tail_q + ptr_t'(push_cnt);
    count_d = count_q + push_cnt - pop_cnt;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // NOTE: storage is cleared on reset as well, so every entry holds a defined
  // all-zero value out of reset rather than X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together from pre-edge values.
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      next_id_q <= ID_ONE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      next_id_q <= next_id_d;
      if (wr_a) mem_q[tail_q] <= entry_a;
      if (wr_b) mem_q[tail_q + PTR_ONE] <= entry_b;
    end
  end

  always_comb begin
    slot0 = '0;
    slot1 = '0;
    if (count_q >= CNT_ONE) slot0 = mem_q[head_q];
    if (count_q >= CNT_TWO) slot1 = mem_q[head_q + PTR_ONE];
  end

  assign instruction0_out = slot0.inst;
  assign instruction1_out = slot1.inst;
  assign pc0_out          = slot0.pc;
  assign pc1_out          = slot1.pc;
  assign id0_out          = slot0.id;
  assign id1_out          = slot1.id;
  assign count            = count_q;

endmodule
